// File: rtl/mtsp_gscs_pkg.sv
// Shared types and helpers for the GSC sequencer: component indices and mask-bit mapping.
package mtsp_gscs_pkg;

  typedef enum logic [1:0] {
    GSC_X = 2'd0,
    GSC_Y = 2'd1,
    GSC_Z = 2'd2,
    GSC_W = 2'd3
  } gsc_comp_e;

  localparam int GSC_COMPS = 4;

  // Masks are ordered bit3=X .. bit0=W, so component index c lives at mask bit 3-c.
  function automatic int mask_bit(input int comp);
    return (GSC_COMPS - 1) - comp;
  endfunction

endpackage

// File: rtl/mtsp_gsc_counter.sv
// One CW-bit general scratch coordinate counter with clear/increase/limit.
// Optional macro MTSP_GSC_SATURATE_EN: saturate at the limit instead of wrapping to 0.
module mtsp_gsc_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count_next,
  output logic          wrap_evt
);

  logic [CW-1:0] count_reg;

  // count_next is exported so the read port can observe the post-update value in the same cycle.
  always_comb begin
    count_next = count_reg;
    wrap_evt   = 1'b0;
    if (en) begin
      if (clr) begin
        count_next = '0;
      end else if (inc) begin
        if (count_reg < limit) begin
          count_next = count_reg + 1'b1;
        end else begin
          wrap_evt = 1'b1;
`ifdef MTSP_GSC_SATURATE_EN
          count_next = limit;
`else
          count_next = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else        count_reg <= count_next;
  end

endmodule

// File: rtl/mtsp_gscs_sequencer.sv
// GSC sequencer: THREADS x {X,Y,Z,W} counters, shared wrap limits, update handshake, registered read.
// Optional macro MTSP_GSC_SATURATE_EN selects saturating counters (see mtsp_gsc_counter).
module mtsp_gscs_sequencer
  import mtsp_gscs_pkg::*;
#(
  parameter  int THREADS = 4,
  parameter  int CW      = 8,
  localparam int TW      = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [TW-1:0]   upd_thread,
  input  logic [3:0]      upd_rst,
  input  logic [3:0]      upd_inc,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_comp,
  input  logic [CW-1:0]   cfg_limit,
  input  logic [TW-1:0]   rd_thread,
  output logic [4*CW-1:0] rd_gsc,
  output logic [3:0]      wrap,
  output logic [TW-1:0]   wrap_thread
);

  logic                  accept;
  logic [CW-1:0]         lim_reg [GSC_COMPS];
  logic [CW-1:0]         cnt_next [THREADS][GSC_COMPS];
  logic [THREADS*4-1:0]  wrap_evt_flat;
  logic [3:0]            wrap_next;
  logic [4*CW-1:0]       rd_next;

  // A limit write owns the cycle; the pending update simply waits.
  assign upd_ready = ~cfg_we;
  assign accept    = upd_valid & upd_ready & (32'(upd_thread) < THREADS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < GSC_COMPS; c++) lim_reg[c] <= '1;
    end else if (cfg_we) begin
      lim_reg[cfg_comp] <= cfg_limit;
    end
  end

  genvar gi, gc;
  generate
    for (gi = 0; gi < THREADS; gi++) begin : g_thread
      for (gc = 0; gc < GSC_COMPS; gc++) begin : g_comp
        mtsp_gsc_counter #(.CW(CW)) u_cnt (
          .clk        (clk),
          .rst_n      (rst_n),
          .en         (accept && (upd_thread == TW'(gi))),
          .clr        (upd_rst[mask_bit(gc)]),
          .inc        (upd_inc[mask_bit(gc)]),
          .limit      (lim_reg[gc]),
          .count_next (cnt_next[gi][gc]),
          .wrap_evt   (wrap_evt_flat[gi*4 + mask_bit(gc)])
        );
      end
    end
  endgenerate

  // Only one thread is updated per cycle, so OR-ing across threads is safe.
  always_comb begin
    wrap_next = '0;
    for (int t = 0; t < THREADS; t++) wrap_next |= wrap_evt_flat[t*4 +: 4];
  end

  always_comb begin
    rd_next = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (rd_thread == TW'(t)) begin
        rd_next = {cnt_next[t][GSC_X], cnt_next[t][GSC_Y], cnt_next[t][GSC_Z], cnt_next[t][GSC_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_gsc      <= '0;
      wrap        <= '0;
      wrap_thread <= '0;
    end else begin
      rd_gsc <= rd_next;
      wrap   <= wrap_next;
      if (|wrap_next) wrap_thread <= upd_thread;
    end
  end

endmodule
